// File: rtl/first_nios2_system_sysid_checker.sv
// first_nios2_system_sysid_checker
//
// Avalon-MM read master that checks the system-ID slave. On a start pulse it
// reads word 0 (system ID) and then word 1 (build timestamp). Each value is
// compared against its expected parameter, and the result is reported to the
// boot/health logic.
//
// Ports:
//   clock            system clock, all logic on the rising edge
//   reset_n          asynchronous active-low reset
//   start            single-cycle request to run a check (ignored while busy)
//   avm_address      word address to the sysid slave (0 = ID, 1 = timestamp)
//   avm_read         Avalon read strobe
//   avm_waitrequest  slave/fabric stall
//   avm_readdata     read data, zero read latency
//   busy             check in progress
//   done             one-cycle pulse when a check ends (pass, fail or timeout)
//   id_ok / ts_ok    captured word matched its expected value
//   timeout          a read stalled for TIMEOUT_CYCLES cycles and was abandoned
//   id_value         last captured ID
//   ts_value         last captured timestamp
//
// State table:
//   state  | meaning
//   IDLE   | waiting for start; status and values hold
//   RD_ID  | read of word 0 outstanding
//   RD_TS  | read of word 1 outstanding

module first_nios2_system_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1363436362,
   parameter logic [15:0] TIMEOUT_CYCLES     = 16'd255
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RD_ID = 2'd1,
      ST_RD_TS = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        avm_read_q, avm_read_d;
   logic        avm_address_q, avm_address_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        id_ok_q, id_ok_d;
   logic        ts_ok_q, ts_ok_d;
   logic        timeout_q, timeout_d;
   logic [31:0] id_value_q, id_value_d;
   logic [31:0] ts_value_q, ts_value_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   logic [15:0] stall_inc;
   logic        stall_abort;

   // The counter saturates rather than wrapping. The abort fires on the stalled
   // cycle that brings the count up to TIMEOUT_CYCLES, so avm_read drops after
   // exactly TIMEOUT_CYCLES stalled cycles.
   always_comb begin
      stall_inc   = (stall_cnt_q == 16'hFFFF) ? stall_cnt_q : stall_cnt_q + 16'd1;
      stall_abort = (TIMEOUT_CYCLES != 16'd0) && (stall_inc >= TIMEOUT_CYCLES);
   end

   always_comb begin
      state_d       = state_q;
      avm_read_d    = avm_read_q;
      avm_address_d = avm_address_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      id_ok_d       = id_ok_q;
      ts_ok_d       = ts_ok_q;
      timeout_d     = timeout_q;
      id_value_d    = id_value_q;
      ts_value_d    = ts_value_q;
      stall_cnt_d   = stall_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d       = ST_RD_ID;
               avm_read_d    = 1'b1;
               avm_address_d = 1'b0;
               busy_d        = 1'b1;
               id_ok_d       = 1'b0;
               ts_ok_d       = 1'b0;
               timeout_d     = 1'b0;
               stall_cnt_d   = 16'd0;
            end
         end

         ST_RD_ID: begin
            if (!avm_waitrequest) begin
               id_value_d    = avm_readdata;
               id_ok_d       = (avm_readdata == EXPECTED_ID);
               state_d       = ST_RD_TS;
               avm_address_d = 1'b1;
               stall_cnt_d   = 16'd0;
            end else if (stall_abort) begin
               state_d       = ST_IDLE;
               avm_read_d    = 1'b0;
               avm_address_d = 1'b0;
               busy_d        = 1'b0;
               done_d        = 1'b1;
               timeout_d     = 1'b1;
               stall_cnt_d   = stall_inc;
            end else begin
               stall_cnt_d   = stall_inc;
            end
         end

         ST_RD_TS: begin
            if (!avm_waitrequest) begin
               ts_value_d    = avm_readdata;
               ts_ok_d       = (avm_readdata == EXPECTED_TIMESTAMP);
               state_d       = ST_IDLE;
               avm_read_d    = 1'b0;
               avm_address_d = 1'b0;
               busy_d        = 1'b0;
               done_d        = 1'b1;
            end else if (stall_abort) begin
               state_d       = ST_IDLE;
               avm_read_d    = 1'b0;
               avm_address_d = 1'b0;
               busy_d        = 1'b0;
               done_d        = 1'b1;
               timeout_d     = 1'b1;
               stall_cnt_d   = stall_inc;
            end else begin
               stall_cnt_d   = stall_inc;
            end
         end

         default: begin
            state_d       = ST_IDLE;
            avm_read_d    = 1'b0;
            avm_address_d = 1'b0;
            busy_d        = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         avm_read_q    <= 1'b0;
         avm_address_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         id_ok_q       <= 1'b0;
         ts_ok_q       <= 1'b0;
         timeout_q     <= 1'b0;
         id_value_q    <= 32'd0;
         ts_value_q    <= 32'd0;
         stall_cnt_q   <= 16'd0;
      end else begin
         state_q       <= state_d;
         avm_read_q    <= avm_read_d;
         avm_address_q <= avm_address_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         id_ok_q       <= id_ok_d;
         ts_ok_q       <= ts_ok_d;
         timeout_q     <= timeout_d;
         id_value_q    <= id_value_d;
         ts_value_q    <= ts_value_d;
         stall_cnt_q   <= stall_cnt_d;
      end
   end

   assign avm_read    = avm_read_q;
   assign avm_address = avm_address_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign id_ok       = id_ok_q;
   assign ts_ok       = ts_ok_q;
   assign timeout     = timeout_q;
   assign id_value    = id_value_q;
   assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// Testbench for first_nios2_system_sysid_checker. A behavioural Avalon slave
// serves planned data after a planned number of stall cycles. The expected
// outcome of every check is derived from the stall plan and the data.

module tb_first_nios2_system_sysid_checker;

   localparam logic [31:0] EID = 32'd0;
   localparam logic [31:0] ETS = 32'd1363436362;
   localparam int          T   = 4;

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic        start = 1'b0;
   logic        avm_address;
   logic        avm_read;
   logic        avm_waitrequest = 1'b0;
   logic [31:0] avm_readdata = 32'd0;
   logic        busy, done, id_ok, ts_ok, timeout;
   logic [31:0] id_value, ts_value;

   always #5 clock = ~clock;

   first_nios2_system_sysid_checker #(
      .EXPECTED_ID        (EID),
      .EXPECTED_TIMESTAMP (ETS),
      .TIMEOUT_CYCLES     (16'd4)
   ) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .start           (start),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_waitrequest (avm_waitrequest),
      .avm_readdata    (avm_readdata),
      .busy            (busy),
      .done            (done),
      .id_ok           (id_ok),
      .ts_ok           (ts_ok),
      .timeout         (timeout),
      .id_value        (id_value),
      .ts_value        (ts_value)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Slave model: a new read waits plan_stall[addr] cycles, then returns data.
   int          plan_stall [2];
   logic [31:0] plan_data  [2];
   bit          in_read   = 0;
   int          remaining = 0;
   logic        cur_addr  = 1'b0;
   int          addr_viol = 0;
   int          accepts   = 0;
   logic        acc_addr [4];

   always @(negedge clock) begin
      if (avm_read === 1'b1) begin
         if (!in_read) begin
            in_read   = 1;
            cur_addr  = avm_address;
            remaining = plan_stall[avm_address];
         end else begin
            if (avm_address !== cur_addr) addr_viol++;
            if (remaining > 0) remaining--;
         end
         avm_waitrequest = (remaining != 0);
         avm_readdata    = avm_waitrequest ? $urandom : plan_data[avm_address];
         if (!avm_waitrequest) begin
            in_read = 0;
            if (accepts < 4) acc_addr[accepts] = avm_address;
            accepts++;
         end
      end else begin
         in_read         = 0;
         avm_waitrequest = 1'($urandom_range(0, 1));
         avm_readdata    = $urandom;
      end
   end

   logic [31:0] m_id = 32'd0;
   logic [31:0] m_ts = 32'd0;

   // Caller must be sitting just after a negedge; start is driven immediately.
   task automatic run_check(input logic [31:0] d_id, input logic [31:0] d_ts,
                            input int s_id, input int s_ts,
                            input bit repulse, input bit chain);
      int k_exp, e_acc, k;
      bit e_to, e_idok, e_tsok;
      plan_stall[0] = s_id;
      plan_stall[1] = s_ts;
      plan_data[0]  = d_id;
      plan_data[1]  = d_ts;
      addr_viol = 0;
      accepts   = 0;
      if (s_id >= T) begin
         k_exp = T + 1; e_to = 1; e_idok = 0; e_tsok = 0; e_acc = 0;
      end else if (s_ts >= T) begin
         k_exp = s_id + 2 + T; e_to = 1; e_idok = (d_id == EID); e_tsok = 0; e_acc = 1;
         m_id = d_id;
      end else begin
         k_exp = s_id + s_ts + 3; e_to = 0; e_idok = (d_id == EID); e_tsok = (d_ts == ETS);
         e_acc = 2; m_id = d_id; m_ts = d_ts;
      end
      start = 1'b1;
      k = 0;
      do begin
         @(negedge clock);
         k++;
         if (k == 1) begin
            check_eq("busy_c1", busy, 1);
            check_eq("read_c1", avm_read, 1);
            check_eq("addr_c1", avm_address, 0);
            check_eq("flags_clear_c1", {id_ok, ts_ok, timeout}, 0);
         end
         if (!(repulse && k < 3)) start = 1'b0;
      end while (done !== 1'b1 && k < 40);
      start = 1'b0;
      check_eq("done_cycle", k, k_exp);
      check_eq("id_ok", id_ok, e_idok);
      check_eq("ts_ok", ts_ok, e_tsok);
      check_eq("timeout", timeout, e_to);
      check_eq("id_value", id_value, m_id);
      check_eq("ts_value", ts_value, m_ts);
      check_eq("busy_done", busy, 0);
      check_eq("read_done", avm_read, 0);
      check_eq("accepts", accepts, e_acc);
      check_eq("addr_stable", addr_viol, 0);
      if (e_acc >= 1) check_eq("acc_addr0", acc_addr[0], 0);
      if (e_acc >= 2) check_eq("acc_addr1", acc_addr[1], 1);
      if (!chain) begin
         @(negedge clock);
         check_eq("done_width", done, 0);
      end
   endtask

   initial begin
      plan_stall[0] = 0;
      plan_stall[1] = 0;
      plan_data[0]  = 32'd0;
      plan_data[1]  = 32'd0;
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clock);
      check_eq("rst_read", avm_read, 0);
      check_eq("rst_addr", avm_address, 0);
      check_eq("rst_status", {busy, done, id_ok, ts_ok, timeout}, 0);
      check_eq("rst_id_value", id_value, 0);
      check_eq("rst_ts_value", ts_value, 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      run_check(EID, ETS, 0, 0, 0, 0);
      run_check(32'h0000_0007, ETS, 0, 0, 0, 0);
      run_check(EID, ETS, 3, 3, 0, 0);
      run_check(EID, ETS, 0, 255, 0, 0);
      run_check(EID, ETS, 0, 0, 1, 1);
      run_check(32'h1234_5678, ETS, 1, 0, 0, 0);
      run_check(EID, 32'hDEAD_BEEF, 255, 0, 0, 0);
      run_check(EID, 32'hCAFE_0001, 2, 3, 0, 0);

      for (int i = 0; i < 25; i++) begin
         logic [31:0] rid, rts;
         rid = ($urandom_range(0, 3) == 0) ? $urandom : EID;
         rts = ($urandom_range(0, 3) == 0) ? $urandom : ETS;
         repeat ($urandom_range(0, 2)) @(negedge clock);
         run_check(rid, rts, $urandom_range(0, 6), $urandom_range(0, 6),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      @(negedge clock);

      // Reset while the ID read is stalled.
      plan_stall[0] = 255;
      plan_stall[1] = 255;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      check_eq("pre_rst_read", avm_read, 1);
      #2 reset_n = 1'b0;
      #1;
      check_eq("arst_read", avm_read, 0);
      check_eq("arst_status", {busy, done, id_ok, ts_ok, timeout, avm_address}, 0);
      check_eq("arst_id_value", id_value, 0);
      check_eq("arst_ts_value", ts_value, 0);
      m_id = 32'd0;
      m_ts = 32'd0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      check_eq("post_rst_done", done, 0);
      run_check(EID, ETS, 1, 2, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
